// File: rtl/sigmoid_arb_pkg.sv
// sigmoid_arb_pkg: fixed-point widths, 5.5 saturation bounds and the tag type shared by the
// sigmoid arbiter and its round-robin grant logic.
package sigmoid_arb_pkg;
    localparam int Q88_W   = 16;
    localparam int S55_W   = 10;
    localparam int S28_W   = 10;
    localparam int IDX_W   = 3;
    localparam int SAT_MIN = -512;
    localparam int SAT_MAX = 511;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // Q8.8 -> 5.5: drop three fraction bits (floor), then clamp into the 10-bit signed range.
    function automatic logic [S55_W-1:0] q88_to_s55(input logic [Q88_W-1:0] q);
        logic signed [Q88_W-4:0] s;
        s = (Q88_W-3)'($signed(q) >>> 3);
        return s > SAT_MAX ? S55_W'(SAT_MAX) : s < SAT_MIN ? S55_W'(SAT_MIN) : s[S55_W-1:0];
    endfunction
endpackage

// File: rtl/sigmoid_share_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant over N requesters; the search starts at the pointer and the
// pointer moves just past the winner.
module rr_arbiter import sigmoid_arb_pkg::*; #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);
    logic [IDX_W-1:0] ptr;

    // Walk the rotation backwards so the nearest requester after ptr is the last write.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (|(req & (N'(1) << ((int'(ptr) + k) % N)))) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'((int'(ptr) + k) % N);
            end
        end
        grant = grant_any ? N'(1) << grant_idx : '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (grant_any)
            ptr <= int'(grant_idx) == N - 1 ? '0 : grant_idx + 1'b1;
    end
endmodule

// File: rtl/sigmoid_share_arbiter.sv
// sigmoid_share_arbiter: time-shares one pipelined sigmoid unit among NUM_REQ channels and routes
// each result back by tag. Optional perf counters under SIGMOID_ARB_PERF_EN.
module sigmoid_share_arbiter import sigmoid_arb_pkg::*; #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int SIG_IN_W    = 10,
    parameter int SIG_OUT_W   = 10,
    parameter int SIG_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          sig_c_en,
    output logic [SIG_IN_W-1:0]           sig_data_in,
    input  logic [SIG_OUT_W-1:0]          sig_data_out,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
`ifdef SIGMOID_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]         perf_grants,
    output logic [15:0]                   perf_stall
`endif
);
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             inflight;
    tag_t             tags [SIG_LATENCY];

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid & {NUM_REQ{~reset}}),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sig_c_en    = grant_any;
    assign sig_data_in = grant_any ? SIG_IN_W'(q88_to_s55(Q88_W'(req_data >> (int'(grant_idx) * DATA_WIDTH)))) : '0;

    always_comb begin
        inflight = 1'b0;
        for (int k = 0; k < SIG_LATENCY; k++)
            inflight |= tags[k].valid;
    end

    assign busy = ~reset & (|req_valid | inflight);

    // The tag pipe mirrors the unit's latency so the last stage lines up with sig_data_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SIG_LATENCY; k++)
                tags[k] <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            tags[0] <= '{valid: grant_any, idx: grant_idx};
            for (int k = 1; k < SIG_LATENCY; k++)
                tags[k] <= tags[k-1];
            rsp_valid <= tags[SIG_LATENCY-1].valid ? NUM_REQ'(1) << tags[SIG_LATENCY-1].idx : '0;
            if (tags[SIG_LATENCY-1].valid)
                rsp_data <= DATA_WIDTH'(sig_data_out);
        end
    end

`ifdef SIGMOID_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i] && perf_grants[i*16 +: 16] != 16'hFFFF)
                    perf_grants[i*16 +: 16] <= perf_grants[i*16 +: 16] + 16'd1;
            if (|(req_valid & ~req_ready) && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// tb_sigmoid_share_arbiter: scoreboard bench with a hard-sigmoid model of the shared unit
// (y = 0.5 + x/4, clamped to [0,1]) and a queue-per-channel requester model.
module tb_sigmoid_share_arbiter;
    localparam int NR  = 4;
    localparam int LAT = 3;

    logic              clk = 0;
    logic              reset = 1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*16-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready, rsp_valid;
    logic              sig_c_en, busy;
    logic [9:0]        sig_data_in, sig_data_out;
    logic [15:0]       rsp_data;
`ifdef SIGMOID_ARB_PERF_EN
    logic [NR*16-1:0]  perf_grants;
    logic [15:0]       perf_stall;
`endif

    typedef struct {int ch; int data; int cyc;} item_t;
    item_t       sb[$];
    item_t       rlog[$];
    logic [15:0] chq [NR][$];
    int          sin_log[$], rdy_log[$];
    logic [9:0]  unit_q [LAT];
    int          ptr = 0, cyc = 0, errors = 0, checks = 0;
    bit          armed = 0;

    sigmoid_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(16), .SIG_IN_W(10), .SIG_OUT_W(10), .SIG_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .sig_c_en     (sig_c_en),
        .sig_data_in  (sig_data_in),
        .sig_data_out (sig_data_out),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy)
`ifdef SIGMOID_ARB_PERF_EN
        ,
        .perf_grants  (perf_grants),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int conv(input logic [15:0] d);
        int s;
        s = $signed(d);
        s = s >>> 3;
        if (s > 511) s = 511;
        if (s < -512) s = -512;
        return s & 1023;
    endfunction

    function automatic int hs(input int raw);
        int v, y;
        v = raw >= 512 ? raw - 1024 : raw;
        y = 128 + 2 * v;
        return y < 0 ? 0 : y > 256 ? 256 : y;
    endfunction

    // Stand-in for the external unit: LAT register stages, cleared by the shared reset.
    always @(posedge clk) begin
        unit_q[0] <= reset ? '0 : 10'(hs(int'(sig_data_in)));
        for (int k = 1; k < LAT; k++)
            unit_q[k] <= reset ? '0 : unit_q[k-1];
    end
    assign sig_data_out = unit_q[LAT-1];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic item_t rget(input int i);
        item_t z = '{-1, -1, -1};
        return i < rlog.size() ? rlog[i] : z;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    always @(negedge clk) begin
        item_t e;
        if (armed && rsp_valid != '0) begin
            rlog.push_back('{int'(rsp_valid), int'(rsp_data), cyc});
            if (sb.size() == 0)
                chk("rsp_unexpected", int'(rsp_valid), 0);
            else begin
                e = sb.pop_front();
                chk("rsp_valid", int'(rsp_valid), 1 << e.ch);
                chk("rsp_data", int'(rsp_data), e.data);
                chk("rsp_latency", cyc - e.cyc, LAT + 1);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = chq[i].size() > 0;
            req_data[i*16 +: 16] = chq[i].size() > 0 ? chq[i][0] : 16'h0;
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NR; i++)
            if (chq[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic step();
        int g;
        logic [15:0] d;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (ptr + k) % NR;
            if (g < 0 && chq[j].size() > 0) g = j;
        end
        chk("req_ready", int'(req_ready), g < 0 ? 0 : 1 << g);
        chk("sig_c_en", int'(sig_c_en), int'(g >= 0));
        rdy_log.push_back(int'(req_ready));
        if (g >= 0) begin
            d = chq[g][0];
            chk("sig_data_in", int'(sig_data_in), conv(d));
            sin_log.push_back(int'(sig_data_in));
            sb.push_back('{g, hs(conv(d)), cyc});
        end
        @(posedge clk);
        if (g >= 0) begin
            void'(chq[g].pop_front());
            ptr = (g + 1) % NR;
        end
        #1 drive();
    endtask

    task automatic drain();
        int n = 0;
        while ((pending() || sb.size() > 0) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) chq[i].delete();
        reset = 1;
        drive();
        @(posedge clk);
        sb.delete();
        ptr = 0;
        @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        reset = 1;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_sig_c_en", int'(sig_c_en), 0);
        chk("reset_sig_data_in", int'(sig_data_in), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_data", int'(rsp_data), 0);
        chk("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1 reset = 0;
        armed = 1;

        // single zero operand on channel 0
        rlog.delete(); sin_log.delete();
        chq[0].push_back(16'h0000);
        drive();
        step();
        chk("busy_inflight", int'(busy), 1);
        drain();
        chk("t1_sig_in", qget(sin_log, 0), 'h000);
        chk("t1_rsp_valid", rget(0).ch, 'b0001);
        chk("t1_rsp_data", rget(0).data, 'h0080);
        chk("idle_busy", int'(busy), 0);

        // back-to-back on channel 2
        rlog.delete();
        chq[2].push_back(16'h0300);
        chq[2].push_back(16'hFD00);
        drive();
        drain();
        chk("t2_count", rlog.size(), 2);
        chk("t2_valid0", rget(0).ch, 'b0100);
        chk("t2_data0", rget(0).data, 'h0100);
        chk("t2_valid1", rget(1).ch, 'b0100);
        chk("t2_data1", rget(1).data, 'h0000);
        chk("t2_consecutive", rget(1).cyc - rget(0).cyc, 1);

        // conversion saturation and truncation
        sin_log.delete();
        chq[1].push_back(16'h7FFF);
        chq[1].push_back(16'h8000);
        chq[1].push_back(16'h0108);
        drive();
        drain();
        chk("sat_pos", qget(sin_log, 0), 'h1FF);
        chk("sat_neg", qget(sin_log, 1), 'h200);
        chk("trunc", qget(sin_log, 2), 'h021);

        // all four channels: strict rotation from channel 0
        do_reset();
        rdy_log.delete(); rlog.delete();
        for (int i = 0; i < NR; i++)
            repeat (2) chq[i].push_back(16'($urandom));
        drive();
        drain();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_grant%0d", k), qget(rdy_log, k), 1 << (k % 4));
            chk($sformatf("rr_rsp%0d", k), rget(k).ch, 1 << (k % 4));
        end

        // reset while three results are in flight
        for (int i = 0; i < 3; i++) chq[i].push_back(16'h0100);
        drive();
        repeat (3) step();
        rlog.delete();
        do_reset();
        repeat (8) step();
        chk("midreset_no_rsp", rlog.size(), 0);
        chk("midreset_busy", int'(busy), 0);
        rdy_log.delete();
        for (int i = 0; i < NR; i++) chq[i].push_back(16'h0040);
        drive();
        drain();
        chk("midreset_ptr0", qget(rdy_log, 0), 'b0001);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 3) == 0 && chq[i].size() < 3)
                    chq[i].push_back($urandom_range(0, 1) != 0 ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024);
            drive();
            step();
        end
        drain();
        chk("final_busy", int'(busy), 0);

`ifdef SIGMOID_ARB_PERF_EN
        do_reset();
        repeat (10) begin
            chq[0].push_back(16'h0010);
            chq[1].push_back(16'h0020);
        end
        drive();
        repeat (10) step();
        chk("perf_grants0", int'(perf_grants[15:0]), 5);
        chk("perf_grants1", int'(perf_grants[31:16]), 5);
        chk("perf_grants2", int'(perf_grants[47:32]), 0);
        chk("perf_grants3", int'(perf_grants[63:48]), 0);
        chk("perf_stall", int'(perf_stall), 10);
        for (int i = 0; i < NR; i++) chq[i].delete();
        drive();
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sigmoid_share_arbiter.md
Name: sigmoid_share_arbiter

Overview:
Shares one pipelined sigmoid_function instance among NUM_REQ neuron channels in the activation stage. Each cycle it picks one channel round-robin and converts that channel's Q8.8 operand to the unit's 5.5 input format. It tracks the channel tag through the unit's fixed latency and returns the 2.8 result, widened to Q8.8, to the originating channel.
The unit itself is instantiated outside this block; this block only drives and observes it.

Parameters:
NUM_REQ, 4, number of requesting channels (2..8)
DATA_WIDTH, 16, requester operand/result width, Q8.8
SIG_IN_W, 10, shared unit input width, 5.5 two's complement
SIG_OUT_W, 10, shared unit output width, 2.8 unsigned
SIG_LATENCY, 3, cycles from sig_c_en/sig_data_in sampled to sig_data_out valid

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-channel operand valid
req_data  in  NUM_REQ*DATA_WIDTH  packed Q8.8 operands; channel i at [i*16+:16]
req_ready  out  NUM_REQ  one-hot grant; the operand is consumed when valid&ready
sig_c_en  out  1  to unit c_en; high on an issue cycle
sig_data_in  out  SIG_IN_W  to unit data_in
sig_data_out  in  SIG_OUT_W  from unit data_out
rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle; no backpressure
rsp_data  out  DATA_WIDTH  Q8.8 result, valid with rsp_valid
busy  out  1  high while any tag is in flight or any req_valid is high

Behaviour:
- Reset values: req_ready=0, sig_c_en=0, sig_data_in=0, rsp_valid=0, rsp_data=0, busy=0, rr_ptr=0, tag pipe cleared.
- Arbitration (combinational):
  - Start from rr_ptr, search upward with wrap.
  - The first i with req_valid[i] gets req_ready[i]=1. All other req_ready bits are 0.
  - No valid request -> req_ready=0.
- Pointer: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Issue: sig_c_en and sig_data_in are combinational from the grant, so the unit samples them at the grant edge.
- Conversion Q8.8 -> 5.5:
  - Arithmetic shift right by 3 (truncate toward -inf).
  - Saturate to [-512, +511]: 0x7FFF -> 0x1FF, 0x8000 -> 0x200.
- Tag pipe:
  - SIG_LATENCY stages, each holding {valid, channel index}.
  - Stage 0 loads {grant_any, grant_idx} every cycle; then shift.
- Response:
  - When the last stage is valid, on the next edge: rsp_valid <= onehot(idx), rsp_data <= zero-extended {6'b0, sig_data_out}.
  - Otherwise rsp_valid <= 0 and rsp_data holds.
  - Total latency from accept edge to rsp_valid high: SIG_LATENCY+1 cycles.
- Throughput: one issue per cycle. Results leave in issue order.
- Back-to-back grants to the same channel are allowed when it is the only one requesting. Its results then return on consecutive cycles.
- Results for idle cycles (sig_c_en=0) are ignored because their tag is invalid.
- Reset mid-operation:
  - All tags are dropped; the unit's in-flight results are discarded.
  - rsp_valid is 0 from the first post-reset cycle.
  - The unit is reset by the same reset.
- NUM_REQ=1 degenerates to pass-through with rr_ptr fixed at 0.

Optional Feature:
SIGMOID_ARB_PERF_EN:
- Defined: adds output perf_grants (NUM_REQ*16) with per-channel saturating grant counters, and perf_stall (16), which counts cycles where some req_valid bit was high but not granted.
- perf_stall saturates at 0xFFFF; all counters clear on reset.
- Not defined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Package sigmoid_arb_pkg holds:
  - the Q8.8/5.5/2.8 width constants;
  - the conversion saturation bounds (-512/511);
  - the tag struct {valid, idx[$clog2(NUM_REQ)]}.
- Sub-module rr_arbiter holds the round-robin grant logic plus pointer (parameter N; ports clk, reset, req, grant, grant_idx, grant_any).
- The conversion and tag pipe stay in the top.

Test Plan:
- Single channel 0, req_data=0x0000 -> sig_data_in=0x000; rsp_valid=0001 with rsp_data=0x0080 at SIG_LATENCY+1 cycles after accept.
- Channel 2 sends 0x0300 then 0xFD00 -> rsp_data 0x0100 then 0x0000, rsp_valid=0100 both times, consecutive cycles.
- Conversion saturation: 0x7FFF -> sig_data_in=0x1FF; 0x8000 -> sig_data_in=0x200; 0x0108 -> 0x021.
- All 4 channels valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses in the same order; no cycle without a grant.
- Reset asserted 1 cycle after 3 issues -> no rsp_valid ever appears for those issues; busy=0 and rr_ptr=0 after reset.
- With SIGMOID_ARB_PERF_EN, channels 0 and 1 both valid for 10 cycles -> perf_grants={5,5,0,0}, perf_stall=10.
